fb_writer: RTL

Framebuffer write engine that sits directly upstream of the VGA scan-out stage. It accepts pixel, rectangle-fill and clear commands over a valid/ready handshake. It converts each command into a row-major stream of 16-bit word writes into the shared framebuffer RAM that the display reads through `vga_addr`/`q`. One RAM word holds one 16×16-screen-pixel cell of the 40×30 cell grid, with colour in bits [11:0].

---
 rtl/fb_writer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : fb_writer
// Description : Framebuffer write engine. Turns PIXEL / FILL / CLEAR commands
//               into a row-major stream of 16-bit cell writes into the shared
//               framebuffer RAM read by the VGA scan-out stage.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_writer #(
  parameter logic [15:0] MEM_W     = 16'd40,
  parameter logic [15:0] MEM_H     = 16'd30,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_x0,
  input  logic [15:0] cmd_y0,
  input  logic [15:0] cmd_x1,
  input  logic [15:0] cmd_y1,
  input  logic [11:0] cmd_color,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  input  logic        wr_ready,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] OP_PIXEL = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] x0_q, x0_d;      // left column of the active region
  logic [15:0] x1_q, x1_d;      // right column (inclusive)
  logic [15:0] y1_q, y1_d;      // bottom row (inclusive)
  logic [15:0] cx_q, cx_d;      // column of the write being presented
  logic [15:0] cy_q, cy_d;      // row of the write being presented
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        wr_en_q, wr_en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Region of the incoming command after op decode and FILL clamping
  logic [15:0] rx0, ry0, rx1, ry1;
  logic [15:0] start_addr;
  logic        reject;

  // Decode the command region, validate it and compute its first address
  always_comb begin
    rx0 = cmd_x0;
    ry0 = cmd_y0;
    rx1 = cmd_x0;
    ry1 = cmd_y0;
    case (cmd_op)
      OP_FILL: begin
        rx1 = (cmd_x1 > MEM_W - 16'd1) ? MEM_W - 16'd1 : cmd_x1;
        ry1 = (cmd_y1 > MEM_H - 16'd1) ? MEM_H - 16'd1 : cmd_y1;
      end
      OP_CLEAR: begin
        rx0 = 16'd0;
        ry0 = 16'd0;
        rx1 = MEM_W - 16'd1;
        ry1 = MEM_H - 16'd1;
      end
      default: ;  // PIXEL and reserved use the single-cell region
    endcase
    reject = (cmd_op == OP_RSVD) || (rx0 >= MEM_W) || (ry0 >= MEM_H) ||
             (rx0 > rx1) || (ry0 > ry1);
    // Row stride is a parameter, so this product reduces to shifts and adds
    start_addr = BASE_ADDR + ry0 * MEM_W + rx0;
  end

  // Next-state logic: accept/reject in IDLE, walk the region in RUN
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = wr_en_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RUN;
            x0_d    = rx0;
            x1_d    = rx1;
            y1_d    = ry1;
            cx_d    = rx0;
            cy_d    = ry0;
            addr_d  = start_addr;
            data_d  = {4'h0, cmd_color};
            wr_en_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Outputs hold while the RAM port stalls us
        if (wr_en_q && wr_ready) begin
          if (cx_q < x1_q) begin
            cx_d   = cx_q + 16'd1;
            addr_d = addr_q + 16'd1;
          end else if (cy_q < y1_q) begin
            cx_d   = x0_q;
            cy_d   = cy_q + 16'd1;
            addr_d = addr_q + MEM_W - (x1_q - x0_q);
          end else begin
            state_d = S_IDLE;
            wr_en_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any command in flight at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x0_q    <= 16'd0;
      x1_q    <= 16'd0;
      y1_q    <= 16'd0;
      cx_q    <= 16'd0;
      cy_q    <= 16'd0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign wr_en     = wr_en_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire
